// File: rtl/vic_sound.sv
// VIC-style sound generator: three square-wave tone voices, one LFSR
// noise voice, mixed as (active voice count) x master amplitude.
module vic_sound #(
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ena4,
  input  logic [7:0] i_base_sound,
  input  logic [7:0] i_alto_sound,
  input  logic [7:0] i_soprano_sound,
  input  logic [7:0] i_noise_sound,
  input  logic [3:0] i_amplitude,
  output logic [5:0] o_audio
);

  logic [5:0]      presc;
  logic [3:0][7:0] snd;
  logic [3:0][6:0] cnt;
  logic [3:0]      q;
  logic [3:0]      tick;
  logic [15:0]     lfsr;
  logic            fb;
  logic            rise3;
  logic            noise;
  logic [2:0]      active;
  logic [5:0]      mix;

  always_comb begin
    snd[0] = i_base_sound;
    snd[1] = i_alto_sound;
    snd[2] = i_soprano_sound;
    snd[3] = i_noise_sound;
  end

  // Each voice divides the prescaler by a further factor of two
  always_comb begin
    tick[0] = i_ena4 & (presc == 6'd63);
    tick[1] = i_ena4 & (presc[4:0] == 5'd31);
    tick[2] = i_ena4 & (presc[3:0] == 4'd15);
    tick[3] = i_ena4 & (presc[2:0] == 3'd7);
  end

  always_comb begin
    fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    rise3  = snd[3][7] & tick[3] & (cnt[3] == 7'd127) & ~q[3];
    noise  = lfsr[0] & q[3] & snd[3][7];
    active = {2'b00, q[0]} + {2'b00, q[1]}
           + {2'b00, q[2]} + {2'b00, noise};
    mix    = 6'(active) * 6'(i_amplitude);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      cnt     <= '0;
      q       <= '0;
      lfsr    <= LFSR_SEED;
      o_audio <= '0;
    end else begin
      if (i_ena4)
        presc <= presc + 6'd1;
      for (int i = 0; i < 4; i++) begin
        if (!snd[i][7]) begin
          cnt[i] <= snd[i][6:0];
          q[i]   <= 1'b0;
        end else if (tick[i]) begin
          if (cnt[i] == 7'd127) begin
            cnt[i] <= snd[i][6:0];
            q[i]   <= ~q[i];
          end else begin
            cnt[i] <= cnt[i] + 7'd1;
          end
        end
      end
      if (rise3)
        lfsr <= {lfsr[14:0], fb};
      o_audio <= mix;
    end
  end

endmodule

// File: tb/tb_vic_sound.sv
// Bench for vic_sound: two instances (seed 0001 and FFFF) share stimulus;
// expected samples are queued per cycle and checked by a monitor.
module tb_vic_sound;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena4 = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] alto = '0;
  logic [7:0] sop = '0;
  logic [7:0] nse = '0;
  logic [3:0] amp = '0;
  logic [5:0] audio1;
  logic [5:0] audio2;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [5:0] e1;
    logic [5:0] e2;
    string      nm;
  } exp_t;

  exp_t sbq[$];

  vic_sound dut (
    .clk(clk), .reset(reset), .i_ena4(ena4),
    .i_base_sound(base), .i_alto_sound(alto),
    .i_soprano_sound(sop), .i_noise_sound(nse),
    .i_amplitude(amp), .o_audio(audio1)
  );

  vic_sound #(.LFSR_SEED(16'hFFFF)) dut_ff (
    .clk(clk), .reset(reset), .i_ena4(ena4),
    .i_base_sound(base), .i_alto_sound(alto),
    .i_soprano_sound(sop), .i_noise_sound(nse),
    .i_amplitude(amp), .o_audio(audio2)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t it;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      it = sbq.pop_front();
      n_chk++;
      if (it.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d reached at %0d",
                 it.nm, it.cyc, cyc);
      end else begin
        if (audio1 !== it.e1) begin
          n_fail++;
          $display("FAIL %s seed0001 cyc %0d: got %0d want %0d",
                   it.nm, cyc, audio1, it.e1);
        end
        n_chk++;
        if (audio2 !== it.e2) begin
          n_fail++;
          $display("FAIL %s seedFFFF cyc %0d: got %0d want %0d",
                   it.nm, cyc, audio2, it.e2);
        end
      end
    end
  end

  function automatic void push(input int c, input logic [5:0] a,
                               input logic [5:0] b, input string nm);
    sbq.push_back('{cyc: c, e1: a, e2: b, nm: nm});
  endfunction

  function automatic logic [15:0] step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] a,
                       input logic [7:0] s, input logic [7:0] n,
                       input logic [3:0] am, output int r);
    base  = b;
    alto  = a;
    sop   = s;
    nse   = n;
    amp   = am;
    ena4  = 1'b1;
    reset = 1'b1;
    r     = cyc + 1;
  endtask

  // Square tone: toggles at pulse first + per*m; output lags q by one clk
  task automatic tone(input int r, input int first, input int per,
                      input int n, input logic [5:0] hi);
    logic [5:0] old_v;
    logic [5:0] new_v;
    push(r, 6'd0, 6'd0, "reset_state");
    for (int m = 0; m < n; m++) begin
      old_v = (m % 2 == 1) ? hi : 6'd0;
      new_v = (m % 2 == 1) ? 6'd0 : hi;
      push(r + first + per * m, old_v, old_v, "tone_before");
      push(r + first + per * m + 1, new_v, new_v, "tone_after");
    end
  endtask

  initial begin
    int          r;
    int          k;
    int          p;
    logic [15:0] m1;
    logic [15:0] m2;

    repeat (3) @(negedge clk);

    // soprano f=126: first toggle at pulse 2048, then every 32
    start(8'h00, 8'h00, 8'hFE, 8'h00, 4'd15, r);
    tone(r, 2048, 32, 5, 6'd15);
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + 2048 + 128 + 10);

    // reset mid-run with ena4 high: restart must take full 2048 pulses
    start(8'h00, 8'h00, 8'hFE, 8'h00, 4'd15, r);
    tone(r, 2048, 32, 2, 6'd15);
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + 2048 + 32 + 5);

    // alto f=127, amplitude 4
    start(8'h00, 8'hFF, 8'h00, 8'h00, 4'd4, r);
    tone(r, 4096, 32, 3, 6'd4);
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + 4096 + 64 + 5);

    // soprano f=64, disable mid-period then re-enable
    start(8'h00, 8'h00, 8'hC0, 8'h00, 4'd15, r);
    push(r, 6'd0, 6'd0, "reset_state");
    push(r + 2048, 6'd0, 6'd0, "c0_before");
    push(r + 2049, 6'd15, 6'd15, "c0_after");
    push(r + 2349, 6'd15, 6'd15, "dis_lag");
    push(r + 2350, 6'd0, 6'd0, "dis_zero");
    push(r + 3080, 6'd0, 6'd0, "dis_hold");
    push(r + 4016, 6'd0, 6'd0, "reen_before");
    push(r + 4017, 6'd15, 6'd15, "reen_after");
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + 2348);
    sop = 8'h40;
    wait_cyc(r + 3000);
    sop = 8'hC0;
    wait_cyc(r + 4020);

    // noise voice alone, amplitude 1: output exposes LFSR bit0 while q3=1
    start(8'h00, 8'h00, 8'h00, 8'hFF, 4'd1, r);
    m1 = 16'h0001;
    m2 = 16'hFFFF;
    push(r, 6'd0, 6'd0, "reset_state");
    push(r + 1024, 6'd0, 6'd0, "noise_before");
    for (int i = 0; i < 16; i++) begin
      m1 = step(m1);
      m2 = step(m2);
      push(r + 1025 + 16 * i, {5'd0, m1[0]}, {5'd0, m2[0]}, "noise_hi");
      push(r + 1033 + 16 * i, 6'd0, 6'd0, "noise_lo");
    end
    push(r + 1300, 6'd0, 6'd0, "noise_off");
    for (int i = 0; i < 4; i++) begin
      m1 = step(m1);
      m2 = step(m2);
      push(r + 1409 + 16 * i, {5'd0, m1[0]}, {5'd0, m2[0]}, "noise_resume");
      push(r + 1417 + 16 * i, 6'd0, 6'd0, "noise_lo2");
    end
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + 1276);
    nse = 8'h7F;
    wait_cyc(r + 1400);
    nse = 8'hFF;
    wait_cyc(r + 1480);

    // all voices f=127: all q high at pulses 8192+128k after 449+8k rises
    start(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd15, r);
    m1 = 16'h0001;
    m2 = 16'hFFFF;
    for (int i = 0; i < 449; i++) begin
      m1 = step(m1);
      m2 = step(m2);
    end
    k = 0;
    while (k < 32 && m2[0] == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        m1 = step(m1);
        m2 = step(m2);
      end
      k++;
    end
    p = 8192 + 128 * k;
    push(r, 6'd0, 6'd0, "reset_state");
    push(r + p, 6'd0, 6'd0, "mix_before");
    push(r + p + 1, m1[0] ? 6'd60 : 6'd45, m2[0] ? 6'd60 : 6'd45, "mix_full");
    push(r + p + 2, 6'd0, 6'd0, "amp_zero");
    wait_cyc(r);
    reset = 1'b0;
    wait_cyc(r + p + 1);
    amp = 4'd0;
    wait_cyc(r + p + 6);

    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, want 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vic_sound.md
VIC_SOUND -- requirements
Module: vic_sound

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'h0001, the noise LFSR reset value; a value of 0 is illegal.
REQ-002 SHALL have port clk  input  1  system clock (25 MHz); all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_ena4  input  1  single-cycle 4 MHz clock-enable strobe.
REQ-005 SHALL have port i_base_sound  input  8  bit7 enable, bits6:0 frequency (f) of voice 0.
REQ-006 SHALL have port i_alto_sound  input  8  same format, voice 1.
REQ-007 SHALL have port i_soprano_sound  input  8  same format, voice 2.
REQ-008 SHALL have port i_noise_sound  input  8  same format, noise voice 3.
REQ-009 SHALL have port i_amplitude  input  4  master volume 0..15.
REQ-010 SHALL have port o_audio  output  6  unsigned mixed sample 0..60.

Function
REQ-011 SHALL keep a 6-bit prescaler incremented by 1 on every cycle with i_ena4=1, wrapping 63->0; it SHALL hold when i_ena4=0.
REQ-012 SHALL raise voice ticks only on cycles with i_ena4=1: voice0 when prescaler[5:0]==63, voice1 when [4:0]==31, voice2 when [3:0]==15, voice3 when [2:0]==7, all evaluated on the pre-increment prescaler value.
REQ-013 Each voice SHALL own a 7-bit counter and 1-bit output q; on its tick with counter==127 it SHALL load f and invert q, otherwise increment the counter.
REQ-014 Toggle period SHALL therefore be (128-f) ticks; f=127 SHALL toggle on every tick; f=0 SHALL toggle every 128 ticks.
REQ-015 A frequency change mid-period SHALL take effect only at the next reload; the counter in flight SHALL NOT be altered.
REQ-016 With enable bit7=0 a voice SHALL, on every cycle, load its counter with f and force q=0; on re-enable counting SHALL resume from f at the next tick.
REQ-017 Voice3 SHALL hold a 16-bit LFSR that shifts left once per voice3 q rising transition (0->1), feeding in b15^b13^b12^b10; the noise output SHALL be LFSR bit0 ANDed with voice3 q and enable.
REQ-018 The LFSR SHALL NOT shift while voice3 is disabled and SHALL never reach 16'h0000.
REQ-019 Voices 0-2 contribute q; voice3 contributes the noise output; the mix SHALL be the count of active contributions (0..4) multiplied by i_amplitude, 6-bit result with no overflow (max 4*15=60).
REQ-020 o_audio SHALL be a register updated every clk cycle from current voice state and i_amplitude; latency from a q change to o_audio is exactly 1 clk.
REQ-021 i_amplitude=0 SHALL yield o_audio=0 on the next clk regardless of voices.
REQ-022 Register inputs are sampled every clk; no write strobe is required; inputs changing between ticks SHALL affect only reload values, enables and mix.

Reset
REQ-023 While reset=1: prescaler=0, all voice counters=0, all q=0, LFSR=LFSR_SEED, o_audio=0.
REQ-024 reset SHALL take priority over a simultaneous i_ena4 pulse; no tick SHALL be processed on a reset cycle.
REQ-025 Reset asserted mid-period SHALL discard all progress; after release the first toggle of an enabled voice SHALL occur after 128 of its ticks (counter 0->127 then reload).

Verification
REQ-026 Reset, soprano=8'hFE, amplitude=15, i_ena4 every cycle: first toggle at soprano tick 128, then q toggles every 32 i_ena4 pulses; o_audio alternates 0/15, changing 1 clk after each toggle.
REQ-027 Alto=8'hFF, amplitude=4: after first reload q toggles on every alto tick (every 32 pulses); o_audio alternates 0/4.
REQ-028 All four voices enabled, f=127, amplitude=15, LFSR forced via seed 16'hFFFF: at a point where all contributions are 1, o_audio=60; drop amplitude to 0 -> o_audio=0 on next clk.
REQ-029 Soprano running f=8'hC0, clear bit7 mid-period: o_audio drops to 0 within 2 clk; set bit7 again: next toggle after 128-64=64 ticks.
REQ-030 Noise enabled, seed 16'h0001: after 16 rising noise q transitions the LFSR matches a reference model and is never 0 over 70000 shifts.
REQ-031 Assert reset for 1 cycle coincident with i_ena4 mid-run: all state equals REQ-023 values next cycle; prescaler is 0, not 1.
